prefetch_queue: RTL and testbench
=================================

// Module: prefetch_queue
// PURPOSE
//  Parametrised instruction prefetch buffer for the next-generation core.
//  Fetches sequential instruction words from the shared instruction/data memory
//  port whenever the core is not using it, and queues them with their addresses
//  in a DEPTH-entry FIFO. A taken branch redirects fetch and flushes stale words.
//  Replaces single-register instruction latching and decouples fetch from execute.
// PARAMETERS
//  AW        8   address width; PC wraps modulo 2^AW
//  IW        15  instruction word width
//  DEPTH     4   FIFO entries, >=2; a power of two is not required
//  RESET_PC  0   first fetch address after reset
// PORTS
//  ph1          in   1                   single clock, rising edge
//  reset        in   1                   asynchronous, active-low (0 = reset)
//  fetch_en     in   1                   1 = fetching allowed
//  core_mem     in   1                   core owns memory port this cycle; no fetch
//  fetch_req    out  1                   fetch read issued at fetch_adr this cycle
//  fetch_adr    out  AW                  fetch address (= fetch PC)
//  mem_rdata    in   IW                  read data, valid the cycle after a fetch_req
//  instr_valid  out  1                   FIFO head valid
//  instr        out  IW                  head instruction word
//  instr_pc     out  AW                  address of head instruction
//  instr_ready  in   1                   consumer takes head when instr_valid=1
//  redirect     in   1                   taken branch: flush and refetch
//  redirect_pc  in   AW                  new fetch address
//  count        out  $clog2(DEPTH+1)     entries held (in-flight not counted)
// BEHAVIOUR
//  Reset (reset=0, async, no clock needed): fetch PC=RESET_PC, count=0,
//   inflight=0, FIFO pointers=0; fetch_req=0, instr_valid=0; instr/instr_pc=0.
//  Issue: fetch_req = fetch_en & ~core_mem & ~redirect & (count+inflight < DEPTH).
//   fetch_req is combinational; fetch_adr = fetch PC at all times.
//   On an issue edge: PC <= PC+1 (wrap, e.g. 0xFF->0x00); inflight <= 1, else 0.
//  Response: a cycle with inflight=1 carries mem_rdata for the previous fetch_adr.
//   It is pushed as {pc, word} at the edge, unless redirect=1 that cycle (dropped).
//   Latency: issue in cycle N -> data in N+1 -> instr_valid in N+2. No bypass.
//   Pipelining: one issue per cycle. Slot reservation (count+inflight) ensures a
//   push never meets a full FIFO; overflow is impossible by construction.
//  Pop: instr_valid = (count != 0); a pop occurs on (instr_valid & instr_ready).
//   instr_ready with empty FIFO is ignored. A push and a pop in one cycle leave
//   count unchanged and may occur at count=DEPTH-1 or count=1.
//  Redirect (one-cycle pulse, may repeat): at the edge count <= 0 and pointers
//   <= 0 (pop and push that cycle discarded), PC <= redirect_pc; no fetch that
//   cycle. inflight <= 0. The first fetch at redirect_pc is issued the next cycle.
//  core_mem: blocks issue only; it does not affect response, pop or redirect.
//  fetch_en=0: issue stops; in-flight word still pushed; FIFO still drains.
//  Reset mid-operation: all state cleared at once. Data on mem_rdata after
//   release is ignored (inflight=0).
// TESTING (DEPTH=4, AW=8; memory word at address a = 0x4000+a)
//  1 Release reset, fetch_en=1, instr_ready=0 -> fetch_req at adr 00,01,02,03
//    on consecutive cycles, then 0. count reaches 4. instr=0x4000, instr_pc=00.
//  2 Continue with instr_ready=1 held -> one pop per cycle, instr_pc 00,01,02..
//    gapless. count stays <=4. fetch_req returns 1 steadily.
//  3 core_mem=1 for 2 cycles mid-stream -> fetch_req=0 those cycles. Address
//    sequence resumes with no skipped or repeated address.
//  4 redirect=1, redirect_pc=0x40 in a cycle with inflight=1 -> next cycle
//    count=0, instr_valid=0, fetch_adr=0x40. Stale word never appears.
//    First instr_pc seen is 0x40 with instr=0x4040.
//  5 redirect_pc=0xFE, ready=1 -> fetch adrs FE,FF,00,01. instr_pc follows.
//  6 Drive reset=0 between clock edges at count=3 -> count=0, instr_valid=0,
//    fetch_req=0 immediately. After release, first fetch adr = RESET_PC.

Source files
------------

// File: rtl/prefetch_queue.sv
// Sequential instruction prefetch buffer: fetches into idle memory-port cycles and
// queues {pc, word} pairs in a DEPTH-entry FIFO; a redirect flushes and refetches.
module prefetch_queue #(
  parameter int          AW       = 8,
  parameter int          IW       = 15,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                         ph1,
  input  logic                         reset,
  input  logic                         fetch_en,
  input  logic                         core_mem,
  output logic                         fetch_req,
  output logic [AW-1:0]                fetch_adr,
  input  logic [IW-1:0]                mem_rdata,
  output logic                         instr_valid,
  output logic [IW-1:0]                instr,
  output logic [AW-1:0]                instr_pc,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [AW-1:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pend_adr_q, pend_adr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] adr_q  [DEPTH];
  logic [IW-1:0] word_q [DEPTH];

  logic          push, pop;
  logic [CW:0]   slots_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An in-flight fetch already owns a slot, so a later push can never overflow.
  assign slots_used = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign fetch_req  = reset & fetch_en & ~core_mem & ~redirect
                    & (slots_used < (CW+1)'(DEPTH));
  assign fetch_adr  = pc_q;

  assign push        = inflight_q & ~redirect;
  assign pop         = (count_q != '0) & instr_ready & ~redirect;
  assign instr_valid = (count_q != '0);
  assign instr       = word_q[rd_ptr_q];
  assign instr_pc    = adr_q[rd_ptr_q];
  assign count       = count_q;

  always_comb begin
    pc_d       = pc_q;
    pend_adr_d = pend_adr_q;
    count_d    = count_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      inflight_d = fetch_req;
      if (fetch_req) begin
        pc_d       = pc_q + AW'(1);
        pend_adr_d = pc_q;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      pc_q       <= AW'(RESET_PC);
      pend_adr_q <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_adr_q <= pend_adr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        word_q[i] <= '0;
      end
    end else if (push) begin
      adr_q[wr_ptr_q]  <= pend_adr_q;
      word_q[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based model of fetch, response, pop and redirect.
module tb_prefetch_queue;
  localparam int AW = 8;
  localparam int IW = 15;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          ph1 = 1'b0;
  logic          reset;
  logic          fetch_en, core_mem, instr_ready, redirect;
  logic [AW-1:0] redirect_pc;
  logic [IW-1:0] mem_rdata;
  logic          fetch_req, instr_valid;
  logic [AW-1:0] fetch_adr, instr_pc;
  logic [IW-1:0] instr;
  logic [CW-1:0] count;

  prefetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .ph1(ph1), .reset(reset), .fetch_en(fetch_en), .core_mem(core_mem),
    .fetch_req(fetch_req), .fetch_adr(fetch_adr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count)
  );

  always #5 ph1 = ~ph1;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: queue of held addresses, fetch PC, one outstanding fetch.
  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_pend;
  bit            m_inflight;
  bit            e_req, e_valid;
  int            e_cnt;
  logic [AW-1:0] e_head;

  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    logic [15:0] w;
    w = 16'h4000 + {8'h00, a};
    return w[IW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = '0;
    m_pend = '0;
    m_inflight = 0;
  endtask

  task automatic drive(input bit fe, input bit cm, input bit rdy, input bit rd,
                       input logic [AW-1:0] rpc);
    fetch_en = fe;
    core_mem = cm;
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    mem_rdata = m_inflight ? word_at(m_pend) : IW'($urandom);
    e_req = fe && !cm && !rd && ((mq.size() + int'(m_inflight)) < DEPTH);
    e_valid = (mq.size() != 0);
    e_cnt = mq.size();
    e_head = e_valid ? mq[0] : '0;
    #2;
  endtask

  task automatic advance();
    @(posedge ph1);
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc;
      m_inflight = 0;
    end else begin
      if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
      if (m_inflight) mq.push_back(m_pend);
      m_inflight = e_req;
      if (e_req) begin
        m_pend = m_pc;
        m_pc = m_pc + 8'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    n_total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", instr_valid); else n_pass++;
    n_total++; if (fetch_req !== 1'b0) $display("FAIL rst_req got %b exp 0", fetch_req); else n_pass++;
    n_total++; if (fetch_adr !== 8'h00) $display("FAIL rst_adr got %h exp 00", fetch_adr); else n_pass++;
    n_total++; if (instr !== 15'h0) $display("FAIL rst_instr got %h exp 0", instr); else n_pass++;
    n_total++; if (instr_pc !== 8'h00) $display("FAIL rst_instr_pc got %h exp 00", instr_pc); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, '0);
      n_total++; if (fetch_req !== (i < 4)) $display("FAIL fill_req cyc %0d got %b exp %b", i, fetch_req, (i < 4)); else n_pass++;
      if (i < 4) begin
        n_total++; if (fetch_adr !== AW'(i)) $display("FAIL fill_adr cyc %0d got %h exp %h", i, fetch_adr, AW'(i)); else n_pass++;
      end
      advance();
    end
    n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL fill_valid got %b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr !== 15'h4000) $display("FAIL fill_instr got %h exp 4000", instr); else n_pass++;
    n_total++; if (instr_pc !== 8'h00) $display("FAIL fill_pc got %h exp 00", instr_pc); else n_pass++;
  endtask

  task automatic test_stream();
    logic [AW-1:0] nxt;
    nxt = 8'h00;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 0, '0);
      n_total++; if (count > 3'd4 || count !== e_cnt[CW-1:0]) $display("FAIL stream_count cyc %0d got %0d exp %0d", i, count, e_cnt); else n_pass++;
      if (i >= 1) begin
        n_total++; if (fetch_req !== 1'b1) $display("FAIL stream_req cyc %0d got %b exp 1", i, fetch_req); else n_pass++;
      end
      if (i < 14) begin
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== nxt) $display("FAIL stream_pc cyc %0d got %b/%h exp 1/%h", i, instr_valid, instr_pc, nxt); else n_pass++;
        nxt = nxt + 8'd1;
      end
      advance();
    end
  endtask

  task automatic test_core_mem();
    logic [AW-1:0] last;
    last = m_pc - 8'd1;
    for (int i = 0; i < 6; i++) begin
      drive(1, (i == 2 || i == 3), 1, 0, '0);
      if (i == 2 || i == 3) begin
        n_total++; if (fetch_req !== 1'b0) $display("FAIL cm_block cyc %0d got %b exp 0", i, fetch_req); else n_pass++;
      end else begin
        n_total++; if (fetch_req !== 1'b1 || fetch_adr !== last + 8'd1) $display("FAIL cm_seq cyc %0d got %b/%h exp 1/%h", i, fetch_req, fetch_adr, last + 8'd1); else n_pass++;
        last = last + 8'd1;
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    bit seen;
    drive(1, 0, 1, 1, 8'h40);
    n_total++; if (fetch_req !== 1'b0 || !m_inflight) $display("FAIL redir_req got %b exp 0 (inflight %0d)", fetch_req, m_inflight); else n_pass++;
    advance();
    drive(1, 0, 1, 0, '0);
    n_total++; if (count !== 3'd0 || instr_valid !== 1'b0) $display("FAIL redir_flush got %0d/%b exp 0/0", count, instr_valid); else n_pass++;
    n_total++; if (fetch_adr !== 8'h40) $display("FAIL redir_adr got %h exp 40", fetch_adr); else n_pass++;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (i > 0) drive(1, 0, 1, 0, '0);
      if (instr_valid === 1'b1) begin
        seen = 1;
        n_total++; if (instr_pc !== 8'h40 || instr !== 15'h4040) $display("FAIL redir_first got %h/%h exp 40/4040", instr_pc, instr); else n_pass++;
      end
      advance();
    end
    if (!seen) begin
      n_total++;
      $display("FAIL redir_timeout got no instr_valid exp valid within 10 cycles");
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] nxt;
    drive(1, 0, 1, 1, 8'hFE);
    advance();
    nxt = 8'hFE;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 0, '0);
      if (i < 4) begin
        n_total++; if (fetch_req !== 1'b1 || fetch_adr !== 8'hFE + AW'(i)) $display("FAIL wrap_adr cyc %0d got %b/%h exp 1/%h", i, fetch_req, fetch_adr, 8'hFE + AW'(i)); else n_pass++;
      end
      if (instr_valid === 1'b1) begin
        n_total++; if (instr_pc !== nxt || instr !== word_at(nxt)) $display("FAIL wrap_pc cyc %0d got %h/%h exp %h/%h", i, instr_pc, instr, nxt, word_at(nxt)); else n_pass++;
        nxt = nxt + 8'd1;
      end
      advance();
    end
    n_total++; if (nxt !== 8'h06) $display("FAIL wrap_pops got next %h exp 06", nxt); else n_pass++;
  endtask

  task automatic test_random();
    bit fe, cm, rdy, rd;
    logic [AW-1:0] rpc;
    for (int i = 0; i < 400; i++) begin
      fe  = ($urandom_range(7) != 0);
      cm  = ($urandom_range(3) == 0);
      rdy = ($urandom_range(1) == 1);
      rd  = ($urandom_range(15) == 0);
      rpc = AW'($urandom);
      drive(fe, cm, rdy, rd, rpc);
      n_total++; if (fetch_req !== e_req) $display("FAIL rnd_req cyc %0d got %b exp %b", i, fetch_req, e_req); else n_pass++;
      n_total++; if (fetch_adr !== m_pc) $display("FAIL rnd_adr cyc %0d got %h exp %h", i, fetch_adr, m_pc); else n_pass++;
      n_total++; if (count !== e_cnt[CW-1:0] || instr_valid !== e_valid) $display("FAIL rnd_count cyc %0d got %0d/%b exp %0d/%b", i, count, instr_valid, e_cnt, e_valid); else n_pass++;
      if (e_valid) begin
        n_total++; if (instr_pc !== e_head || instr !== word_at(e_head)) $display("FAIL rnd_head cyc %0d got %h/%h exp %h/%h", i, instr_pc, instr, e_head, word_at(e_head)); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 8'h10);
    advance();
    for (int i = 0; i < 10 && mq.size() != 3; i++) begin
      drive(1, 0, 0, 0, '0);
      advance();
    end
    drive(1, 0, 0, 0, '0);
    n_total++; if (count !== 3'd3) $display("FAIL rmid_pre got %0d exp 3", count); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (count !== 3'd0 || instr_valid !== 1'b0) $display("FAIL rmid_clear got %0d/%b exp 0/0", count, instr_valid); else n_pass++;
    n_total++; if (fetch_req !== 1'b0) $display("FAIL rmid_req got %b exp 0", fetch_req); else n_pass++;
    model_reset();
    @(posedge ph1);
    #1;
    reset = 1'b1;
    drive(1, 0, 0, 0, '0);
    n_total++; if (fetch_req !== 1'b1 || fetch_adr !== 8'h00) $display("FAIL rmid_first got %b/%h exp 1/00", fetch_req, fetch_adr); else n_pass++;
    advance();
    drive(1, 0, 0, 0, '0);
    n_total++; if (count !== 3'd0) $display("FAIL rmid_junk got %0d exp 0", count); else n_pass++;
    advance();
    drive(1, 0, 0, 0, '0);
    n_total++; if (count !== 3'd1 || instr_pc !== 8'h00 || instr !== 15'h4000) $display("FAIL rmid_head got %0d/%h/%h exp 1/00/4000", count, instr_pc, instr); else n_pass++;
    advance();
  endtask

  initial begin
    reset = 1'b0;
    fetch_en = 1'b1;
    core_mem = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_rdata = '0;
    model_reset();
    #3;
    test_reset();
    @(posedge ph1);
    #1;
    reset = 1'b1;
    test_fill();
    test_stream();
    test_core_mem();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
